// File: rtl/proc_control.sv
// proc_control: multicycle control unit for a small bus-based processor.
// A four-step sequencer (T0..T3) fetches a 9-bit instruction word from DIN
// and drives the register-file, ALU and bus-mux strobes for mv, mvi, add,
// sub and the reserved NOP opcodes.
module proc_control #(
   parameter int DATA_W = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Run,
   input  logic [DATA_W-1:0] DIN,
   output logic [7:0]        RinEn,
   output logic [7:0]        selectR,
   output logic              selectG,
   output logic              selectDin,
   output logic              Ain,
   output logic              Gin,
   output logic              AddSub,
   output logic              IRin,
   output logic              Done
);

   // Sequencer steps. T0 doubles as the idle/fetch step.
   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } stateType;

   // Every control strobe gathered in one word so the whole set can be
   // defaulted and suppressed as a unit.
   typedef struct packed {
      logic [7:0] rinEn;
      logic [7:0] selectR;
      logic       selectG;
      logic       selectDin;
      logic       ain;
      logic       gin;
      logic       addSub;
      logic       irIn;
      logic       done;
   } ctrlType;

   // Opcode field values (IR[8:6]); 100..111 are reserved and act as NOPs.
   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   stateType state;
   stateType nextState;
   logic [8:0] ir;
   logic [2:0] opcode;
   logic [2:0] rx;
   logic [2:0] ry;
   ctrlType    ctrl;

   // Only the low nine bits of DIN carry the instruction; the rest of the
   // word is meaningful to the datapath (mvi immediates) but not to control.
   logic unusedDinBits;
   assign unusedDinBits = ^DIN;

   assign opcode = ir[8:6];
   assign rx     = ir[5:3];
   assign ry     = ir[2:0];

   // One-hot write enable for a register index.
   function automatic logic [7:0] regOneHot(input logic [2:0] idx);
      return 8'd1 << idx;
   endfunction

   // Binary bus-mux select for a register index, upper bits kept clear.
   function automatic logic [7:0] regSelect(input logic [2:0] idx);
      return {5'd0, idx};
   endfunction

   // State and instruction register; synchronous reset aborts any step.
   always_ff @(posedge Clock) begin
      // NOTE: non-blocking assignments keep every register updated from
      // the values present before the edge, independent of statement order.
      if (Reset) begin
         state <= T0;
         ir    <= 9'd0;
      end else begin
         state <= nextState;
         if (state == T0 && Run) begin
            ir <= DIN[8:0];
         end
      end
   end

   // Next-state and control decode from the current step and latched IR.
   always_comb begin
      // NOTE: every output of this block gets a default before the case so
      // no path leaves a signal unassigned and no latch is inferred.
      nextState = T0;
      ctrl      = '0;

      case (state)
         T0: begin
            if (Run) begin
               ctrl.irIn = 1'b1;
               nextState = T1;
            end
         end

         T1: begin
            case (opcode)
               OP_MV: begin
                  ctrl.selectR = regSelect(ry);
                  ctrl.rinEn   = regOneHot(rx);
                  ctrl.done    = 1'b1;
               end
               OP_MVI: begin
                  // The immediate is whatever DIN carries during this step.
                  ctrl.selectDin = 1'b1;
                  ctrl.rinEn     = regOneHot(rx);
                  ctrl.done      = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctrl.selectR = regSelect(rx);
                  ctrl.ain     = 1'b1;
                  nextState    = T2;
               end
               default: begin
                  // Reserved opcodes retire immediately without side effects.
                  ctrl.done = 1'b1;
               end
            endcase
         end

         T2: begin
            // Only add/sub reach T2; opcode bit 0 distinguishes sub.
            ctrl.selectR = regSelect(ry);
            ctrl.gin     = 1'b1;
            ctrl.addSub  = (opcode == OP_SUB);
            nextState    = T3;
         end

         T3: begin
            ctrl.selectG = 1'b1;
            ctrl.rinEn   = regOneHot(rx);
            ctrl.done    = 1'b1;
         end

         default: begin
            nextState = T0;
         end
      endcase
   end

   // Drive the ports; a cycle with Reset high is being aborted, so nothing
   // it would have done (including Done of a dying instruction) is shown.
   always_comb begin
      if (Reset) begin
         {RinEn, selectR, selectG, selectDin, Ain, Gin, AddSub, IRin, Done} = '0;
      end else begin
         RinEn     = ctrl.rinEn;
         selectR   = ctrl.selectR;
         selectG   = ctrl.selectG;
         selectDin = ctrl.selectDin;
         Ain       = ctrl.ain;
         Gin       = ctrl.gin;
         AddSub    = ctrl.addSub;
         IRin      = ctrl.irIn;
         Done      = ctrl.done;
      end
   end

endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control: directed and random stimulus for proc_control, checked
// against a queue-based model that expands each fetched instruction into
// the list of per-cycle control words the instruction set defines.
module tb_proc_control;

   localparam int DATA_W = 16;

   logic              Clock;
   logic              Reset;
   logic              Run;
   logic [DATA_W-1:0] DIN;
   logic [7:0]        RinEn;
   logic [7:0]        selectR;
   logic              selectG;
   logic              selectDin;
   logic              Ain;
   logic              Gin;
   logic              AddSub;
   logic              IRin;
   logic              Done;

   proc_control #(.DATA_W(DATA_W)) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Run       (Run),
      .DIN       (DIN),
      .RinEn     (RinEn),
      .selectR   (selectR),
      .selectG   (selectG),
      .selectDin (selectDin),
      .Ain       (Ain),
      .Gin       (Gin),
      .AddSub    (AddSub),
      .IRin      (IRin),
      .Done      (Done)
   );

   // 10 ns clock.
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   typedef struct packed {
      logic [7:0] rinEn;
      logic [7:0] selectR;
      logic       selectG;
      logic       selectDin;
      logic       ain;
      logic       gin;
      logic       addSub;
      logic       irIn;
      logic       done;
   } obsType;

   int     nChecks = 0;
   int     nPass   = 0;
   int     doneCnt = 0;
   obsType lastObs;
   obsType expQ[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) nPass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Expand one instruction word into the control words of the cycles that
   // follow its fetch, straight from the instruction-set description.
   task automatic pushInstr(input logic [8:0] word);
      obsType r;
      int op;
      int rx;
      int ry;
      op = int'(word[8:6]);
      rx = int'(word[5:3]);
      ry = int'(word[2:0]);
      r = '0;
      case (op)
         0: begin
            r.selectR = 8'(ry);
            r.rinEn   = 8'(1 << rx);
            r.done    = 1'b1;
            expQ.push_back(r);
         end
         1: begin
            r.selectDin = 1'b1;
            r.rinEn     = 8'(1 << rx);
            r.done      = 1'b1;
            expQ.push_back(r);
         end
         2, 3: begin
            r.selectR = 8'(rx);
            r.ain     = 1'b1;
            expQ.push_back(r);
            r = '0;
            r.selectR = 8'(ry);
            r.gin     = 1'b1;
            r.addSub  = (op == 3);
            expQ.push_back(r);
            r = '0;
            r.selectG = 1'b1;
            r.rinEn   = 8'(1 << rx);
            r.done    = 1'b1;
            expQ.push_back(r);
         end
         default: begin
            r.done = 1'b1;
            expQ.push_back(r);
         end
      endcase
   endtask

   // One clock cycle: apply inputs, predict, compare at the falling edge,
   // then advance the model across the rising edge.
   task automatic doCycle(input logic rst, input logic run, input logic [DATA_W-1:0] din);
      obsType expNow;
      obsType obs;
      logic   invOk;
      Reset = rst;
      Run   = run;
      DIN   = din;
      expNow = '0;
      if (!rst) begin
         if (expQ.size() > 0) expNow = expQ[0];
         else expNow.irIn = run;
      end
      @(negedge Clock);
      obs = {RinEn, selectR, selectG, selectDin, Ain, Gin, AddSub, IRin, Done};
      lastObs = obs;
      if (obs.done) doneCnt++;
      check("outputs", 32'(obs), 32'(expNow));
      invOk = !(obs.selectG && obs.selectDin)
              && (!(obs.selectG || obs.selectDin) || obs.selectR == 8'd0)
              && ($countones(obs.rinEn) <= 1);
      check("bus_invariants", 32'(invOk), 32'd1);
      @(posedge Clock);
      #1;
      if (rst) expQ.delete();
      else if (expQ.size() > 0) void'(expQ.pop_front());
      else if (run) pushInstr(din[8:0]);
   endtask

   initial begin
      Reset = 1'b1;
      Run   = 1'b0;
      DIN   = '0;
      @(posedge Clock);
      #1;

      // Reset held: everything quiet even with Run high.
      doCycle(1'b1, 1'b0, 16'h0000);
      doCycle(1'b1, 1'b1, 16'h0015);
      check("reset_irin", 32'(lastObs.irIn), 32'd0);
      doCycle(1'b0, 1'b0, 16'h0000);

      // mv R2,R5.
      doCycle(1'b0, 1'b1, 16'h0015);
      check("fetch_irin", 32'(lastObs.irIn), 32'd1);
      doCycle(1'b0, 1'b0, 16'h0000);
      check("mv_selectR", 32'(lastObs.selectR), 32'd5);
      check("mv_rinEn", 32'(lastObs.rinEn), 32'h04);
      check("mv_done", 32'(lastObs.done), 32'd1);
      doCycle(1'b0, 1'b0, 16'h0000);
      check("mv_back_idle", 32'(lastObs), 32'd0);

      // mvi R7 with the immediate on DIN during T1.
      doCycle(1'b0, 1'b1, 16'h0078);
      doCycle(1'b0, 1'b0, 16'h00A5);
      check("mvi_selectDin", 32'(lastObs.selectDin), 32'd1);
      check("mvi_rinEn", 32'(lastObs.rinEn), 32'h80);
      check("mvi_selectG", 32'(lastObs.selectG), 32'd0);
      check("mvi_done", 32'(lastObs.done), 32'd1);

      // sub R1,R3 with Run toggling during execution.
      doneCnt = 0;
      doCycle(1'b0, 1'b1, 16'h00CB);
      doCycle(1'b0, 1'b1, 16'h0015);
      check("sub_t1_selectR", 32'(lastObs.selectR), 32'd1);
      check("sub_t1_ain", 32'(lastObs.ain), 32'd1);
      doCycle(1'b0, 1'b0, 16'h0015);
      check("sub_t2_selectR", 32'(lastObs.selectR), 32'd3);
      check("sub_t2_addsub", 32'(lastObs.addSub), 32'd1);
      check("sub_t2_gin", 32'(lastObs.gin), 32'd1);
      doCycle(1'b0, 1'b1, 16'h0015);
      check("sub_t3_rinEn", 32'(lastObs.rinEn), 32'h02);
      check("sub_t3_selectG", 32'(lastObs.selectG), 32'd1);
      check("sub_done_count", 32'(doneCnt), 32'd1);

      // add R4,R6 then mv R0,R1 with Run held high throughout.
      doCycle(1'b0, 1'b1, 16'h00A6);
      doCycle(1'b0, 1'b1, 16'h0001);
      doCycle(1'b0, 1'b1, 16'h0001);
      check("add_t2_addsub", 32'(lastObs.addSub), 32'd0);
      doCycle(1'b0, 1'b1, 16'h0001);
      check("add_t3_done", 32'(lastObs.done), 32'd1);
      doCycle(1'b0, 1'b1, 16'h0001);
      check("b2b_fetch", 32'(lastObs.irIn), 32'd1);
      doCycle(1'b0, 1'b0, 16'h0000);
      check("b2b_mv_rinEn", 32'(lastObs.rinEn), 32'h01);

      // add R3,R3 aborted by Reset in T2, then a normal mv R2,R5.
      doCycle(1'b0, 1'b1, 16'h009B);
      doCycle(1'b0, 1'b0, 16'h0000);
      doneCnt = 0;
      doCycle(1'b1, 1'b0, 16'h0000);
      doCycle(1'b0, 1'b0, 16'h0000);
      check("abort_idle", 32'(lastObs), 32'd0);
      doCycle(1'b0, 1'b0, 16'h0000);
      check("abort_no_done", 32'(doneCnt), 32'd0);
      doCycle(1'b0, 1'b1, 16'h0015);
      doCycle(1'b0, 1'b0, 16'h0000);
      check("post_abort_mv", 32'(lastObs.rinEn), 32'h04);

      // Reserved opcode 110 retires with only Done.
      doCycle(1'b0, 1'b1, 16'h0180);
      doCycle(1'b0, 1'b0, 16'h0000);
      check("nop_only_done", 32'(lastObs), 32'h1);

      // Random instructions, Run activity and occasional resets.
      for (int i = 0; i < 600; i++) begin
         doCycle(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 16'($urandom));
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
